// File: rtl/lane_unpacker_pkg.sv
// Shared types and sizing helpers for the lane unpacker.
package lane_unpacker_pkg;

   localparam int unsigned DefaultLanes = 4;
   localparam int unsigned DefaultLaneW = 8;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

   function automatic int unsigned lane_idx_w(int unsigned lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/lane_unpacker_first_set_finder.sv
// Ascending-index priority encoder: index 0 has the highest priority.
module first_set_finder
   import lane_unpacker_pkg::*;
#(
   parameter int unsigned N    = DefaultLanes,
   parameter int unsigned IdxW = lane_idx_w(N)
) (
   input  logic [0:N-1]    vec_i,
   output logic [0:IdxW-1] idx_o,
   output logic            any_o,
   output logic            one_hot_single_o
);

   always_comb begin
      idx_o = '0;
      // Walk downwards so the lowest set index is the one that sticks.
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (vec_i[i]) idx_o = IdxW'(i);
      end
   end

   assign any_o            = |vec_i;
   assign one_hot_single_o = any_o && ((vec_i & (vec_i - N'(1))) == '0);

endmodule

// File: rtl/lane_unpacker.sv
// Serializes a packed {lanes, mask} word into single lanes, skipping disabled ones.
module lane_unpacker
   import lane_unpacker_pkg::*;
#(
   parameter int unsigned LANES  = DefaultLanes,
   parameter int unsigned LANE_W = DefaultLaneW
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [0:LANES*LANE_W+LANES-1]        s_data_i,
   input  logic                                 s_valid_i,
   output logic                                 s_ready_o,
   output logic [0:LANE_W-1]                    m_data_o,
   output logic [0:lane_idx_w(LANES)-1]         m_lane_o,
   output logic                                 m_last_o,
   output logic                                 m_valid_o,
   input  logic                                 m_ready_i
);

   localparam int unsigned IdxW  = lane_idx_w(LANES);
   localparam int unsigned DataW = LANES * LANE_W;

   state_e             state_q, state_d;
   logic [0:DataW-1]   buf_q, buf_d;
   logic [0:LANES-1]   rem_q, rem_d;

   logic [0:IdxW-1]    cur_idx;
   logic               rem_any;
   logic               rem_single;
   logic               accept;
   logic [0:LANES-1]   in_mask;

   first_set_finder #(
      .N    (LANES),
      .IdxW (IdxW)
   ) u_finder (
      .vec_i            (rem_q),
      .idx_o            (cur_idx),
      .any_o            (rem_any),
      .one_hot_single_o (rem_single)
   );

   assign in_mask = s_data_i[DataW +: LANES];
   assign accept  = s_valid_i && s_ready_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q <= '0;
         rem_q <= '0;
      end else begin
         buf_q <= buf_d;
         rem_q <= rem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      rem_d   = rem_q;
      unique case (state_q)
         IDLE: begin
            if (accept && (in_mask != '0)) begin
               buf_d   = s_data_i[0 +: DataW];
               rem_d   = in_mask;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (m_ready_i) begin
               for (int i = 0; i < int'(LANES); i++) begin
                  if (cur_idx == IdxW'(i)) rem_d[i] = 1'b0;
               end
               // Last lane leaving: either refill from a concurrent accept or fall idle.
               if (rem_single) begin
                  if (accept && (in_mask != '0)) begin
                     buf_d = s_data_i[0 +: DataW];
                     rem_d = in_mask;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_valid_o = (state_q == EMIT) && rem_any;
      m_data_o  = '0;
      m_lane_o  = '0;
      m_last_o  = 1'b0;
      s_ready_o = 1'b1;
      if (state_q == EMIT) begin
         s_ready_o = m_ready_i && rem_single;
      end
      if (m_valid_o) begin
         m_lane_o = cur_idx;
         m_last_o = rem_single;
         for (int i = 0; i < int'(LANES); i++) begin
            if (cur_idx == IdxW'(i)) m_data_o = buf_q[i*LANE_W +: LANE_W];
         end
      end
   end

endmodule

// File: tb/tb_lane_unpacker.sv
// Directed self-checking bench for lane_unpacker with LANES=4, LANE_W=8.
module tb_lane_unpacker;

   logic        clk;
   logic        rst_n;
   logic [0:35] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [0:7]  m_data;
   logic [0:1]  m_lane;
   logic        m_last;
   logic        m_valid;
   logic        m_ready;

   int checks = 0;
   int errors = 0;

   lane_unpacker #(
      .LANES  (4),
      .LANE_W (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_data_i  (s_data),
      .s_valid_i (s_valid),
      .s_ready_o (s_ready),
      .m_data_o  (m_data),
      .m_lane_o  (m_lane),
      .m_last_o  (m_last),
      .m_valid_o (m_valid),
      .m_ready_i (m_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({s_ready, m_valid, m_data, m_lane, m_last} !== {1'b1, 1'b0, 8'h00, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h lane=%0d last=%b, want 1 0 00 0 0",
                  s_ready, m_valid, m_data, m_lane, m_last);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if ({s_ready, m_valid, m_data, m_lane, m_last} !== {1'b1, 1'b0, 8'h00, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL idle_after_reset: got rdy=%b vld=%b data=%h lane=%0d last=%b, want 1 0 00 0 0",
                  s_ready, m_valid, m_data, m_lane, m_last);
      end
   endtask

   task automatic test_full_mask();
      logic [7:0] ed [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
      logic       el [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      @(negedge clk);
      s_data  = {8'hA0, 8'hB1, 8'hC2, 8'hD3, 4'b1111};
      s_valid = 1'b1;
      m_ready = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         checks++;
         if ({m_valid, m_data, m_lane, m_last} !== {1'b1, ed[k], 2'(k), el[k]}) begin
            errors++;
            $display("FAIL full_lane%0d: got vld=%b data=%h lane=%0d last=%b, want 1 %h %0d %b",
                     k, m_valid, m_data, m_lane, m_last, ed[k], k, el[k]);
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL full_end_idle: got vld=%b rdy=%b, want 0 1", m_valid, s_ready);
      end
   endtask

   task automatic test_sparse_mask();
      @(negedge clk);
      s_data  = {8'hA0, 8'hB1, 8'hC2, 8'hD3, 4'b1010};
      s_valid = 1'b1;
      m_ready = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      #1;
      checks++;
      if ({m_valid, m_data, m_lane, m_last} !== {1'b1, 8'hA0, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL sparse_first: got vld=%b data=%h lane=%0d last=%b, want 1 a0 0 0",
                  m_valid, m_data, m_lane, m_last);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({m_valid, m_data, m_lane, m_last} !== {1'b1, 8'hC2, 2'd2, 1'b1}) begin
         errors++;
         $display("FAIL sparse_second: got vld=%b data=%h lane=%0d last=%b, want 1 c2 2 1",
                  m_valid, m_data, m_lane, m_last);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({m_valid, m_data} !== {1'b0, 8'h00}) begin
         errors++;
         $display("FAIL sparse_end: got vld=%b data=%h, want 0 00", m_valid, m_data);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      s_data  = {8'hA0, 8'hB1, 8'hC2, 8'hD3, 4'b0001};
      s_valid = 1'b1;
      m_ready = 1'b1;
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept1: got rdy=%b, want 1", s_ready);
      end
      @(negedge clk);
      s_data = {8'h13, 8'h24, 8'h35, 8'h46, 4'b1000};
      #1;
      checks++;
      if ({m_valid, m_data, m_lane, m_last, s_ready} !== {1'b1, 8'hD3, 2'd3, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL b2b_word1: got vld=%b data=%h lane=%0d last=%b rdy=%b, want 1 d3 3 1 1",
                  m_valid, m_data, m_lane, m_last, s_ready);
      end
      @(negedge clk);
      s_valid = 1'b0;
      #1;
      checks++;
      if ({m_valid, m_data, m_lane, m_last} !== {1'b1, 8'h13, 2'd0, 1'b1}) begin
         errors++;
         $display("FAIL b2b_word2: got vld=%b data=%h lane=%0d last=%b, want 1 13 0 1",
                  m_valid, m_data, m_lane, m_last);
      end
      @(negedge clk);
      #1;
      checks++;
      if (m_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: got vld=%b, want 0", m_valid);
      end
   endtask

   task automatic test_zero_mask();
      @(negedge clk);
      s_data  = {8'hA0, 8'hB1, 8'hC2, 8'hD3, 4'b0000};
      s_valid = 1'b1;
      m_ready = 1'b1;
      @(negedge clk);
      s_data = {8'hA0, 8'hB1, 8'hC2, 8'hD3, 4'b0100};
      #1;
      checks++;
      if ({m_valid, s_ready} !== {1'b0, 1'b1}) begin
         errors++;
         $display("FAIL zero_dropped: got vld=%b rdy=%b, want 0 1", m_valid, s_ready);
      end
      @(negedge clk);
      s_valid = 1'b0;
      #1;
      checks++;
      if ({m_valid, m_data, m_lane, m_last} !== {1'b1, 8'hB1, 2'd1, 1'b1}) begin
         errors++;
         $display("FAIL zero_next_word: got vld=%b data=%h lane=%0d last=%b, want 1 b1 1 1",
                  m_valid, m_data, m_lane, m_last);
      end
      @(negedge clk);
      #1;
      checks++;
      if (m_valid !== 1'b0) begin
         errors++;
         $display("FAIL zero_end: got vld=%b, want 0", m_valid);
      end
   endtask

   task automatic test_backpressure_reset();
      @(negedge clk);
      s_data  = {8'hA0, 8'hB1, 8'hC2, 8'hD3, 4'b1111};
      s_valid = 1'b1;
      m_ready = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      #1;
      checks++;
      if ({m_valid, m_data, m_lane} !== {1'b1, 8'hA0, 2'd0}) begin
         errors++;
         $display("FAIL bp_first: got vld=%b data=%h lane=%0d, want 1 a0 0", m_valid, m_data, m_lane);
      end
      @(negedge clk);
      m_ready = 1'b0;
      #1;
      checks++;
      if ({m_valid, m_data, m_lane, m_last, s_ready} !== {1'b1, 8'hB1, 2'd1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL bp_hold1: got vld=%b data=%h lane=%0d last=%b rdy=%b, want 1 b1 1 0 0",
                  m_valid, m_data, m_lane, m_last, s_ready);
      end
      @(negedge clk);
      s_data  = {8'hFF, 8'hEE, 8'hDD, 8'hCC, 4'b1111};
      s_valid = 1'b1;
      #1;
      checks++;
      if ({m_valid, m_data, m_lane, m_last, s_ready} !== {1'b1, 8'hB1, 2'd1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL bp_hold2: got vld=%b data=%h lane=%0d last=%b rdy=%b, want 1 b1 1 0 0",
                  m_valid, m_data, m_lane, m_last, s_ready);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({m_valid, m_data, m_lane, m_last, s_ready} !== {1'b0, 8'h00, 2'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL bp_reset_now: got vld=%b data=%h lane=%0d last=%b rdy=%b, want 0 00 0 0 1",
                  m_valid, m_data, m_lane, m_last, s_ready);
      end
      @(negedge clk);
      s_valid = 1'b0;
      rst_n   = 1'b1;
      m_ready = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({m_valid, m_data, m_lane, m_last, s_ready} !== {1'b0, 8'h00, 2'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL bp_idle_after: got vld=%b data=%h lane=%0d last=%b rdy=%b, want 0 00 0 0 1",
                  m_valid, m_data, m_lane, m_last, s_ready);
      end
   endtask

   initial begin
      test_reset();
      test_full_mask();
      test_sparse_mask();
      test_back_to_back();
      test_zero_mask();
      test_backpressure_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
